result_uart_tx: RTL and testbench
=================================

# result_uart_tx

Consumes the classifier's `done` / `predicted_digit` result from `top` and reports it off-chip as ASCII over a standard 8N1 UART line. It sits beside `top` in the board wrapper. Each rising edge of `done` produces one three-byte message: the digit character, CR, then LF. A one-deep pending slot absorbs a result that arrives while a message is still in flight.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in baud.
- `CLKS_PER_BIT`, derived as CLK_HZ/BAUD (integer division; 868 at defaults): bit period in clocks.
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `done`  in  1  result-valid strobe from `top`; only its rising edge is significant.
- `predicted_digit`  in  4  classifier result; sampled in the cycle the rising edge of `done` is detected.
- `uart_tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high while a message is being transmitted or is pending.
- `overrun`  out  1  one-cycle pulse when a result is dropped.

## Operation
- Edge detect: `done_q` is `done` registered. An edge exists in any cycle where `done`=1 and `done_q`=0. A level held high yields exactly one message.
- Character map: digit 0..9 maps to 0x30+digit. Digit 10..15 maps to 0x3F ('?').
- Message: the mapped character, then 0x0D, then 0x0A.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Frames within a message are sent back to back with no idle gap.
- Sequencer states:
  - IDLE: on an edge, latch the character and go to SEND with byte index 0.
  - SEND: hand bytes 0..2 to the byte transmitter in turn.
  - At the end of byte 2's stop bit: go to IDLE if the pending slot is empty. Otherwise load the pending character, clear the slot, and restart SEND at index 0.
- Pending slot, edge while not IDLE:
  - If the slot is empty, store the mapped character in it.
  - If the slot is full, drop the new result, keep the stored one, and pulse `overrun`.
- Simultaneous events: an edge in the last cycle of the final stop bit is treated as arriving while busy. It lands in the pending slot and is sent back to back.
- Reset, including mid-frame, asynchronously forces:
  - `uart_tx`=1, `busy`=0, `overrun`=0;
  - sequencer in IDLE, pending slot empty, `done_q`=0.
- Reset cuts off any partial frame with no completion.
- Reset values of all outputs: `uart_tx`=1, `busy`=0, `overrun`=0.

## Timing
- Edge detected in cycle N: the start bit appears on `uart_tx` in cycle N+1. `busy` also rises in cycle N+1.
- A message occupies 30 bit periods: 30*CLKS_PER_BIT cycles, 26040 at defaults.
- `busy` falls in the first cycle after the final stop bit completes, provided the pending slot is empty.
- Pending message: its start bit follows the previous stop bit with zero idle cycles. `busy` stays high throughout.
- `overrun` is asserted for the cycle following the dropped edge.
- Edge-to-edge spacing of 2 cycles or more on `done` must be handled. Edges spaced closer than that are not required to be handled.

## Structure
- The shared package `mnist_pkg` holds:
  - ASCII constants: CHAR_ZERO = 0x30, CHAR_BAD = 0x3F, CHAR_CR = 0x0D, CHAR_LF = 0x0A;
  - MSG_LEN = 3;
  - the sequencer state enum.
- Sub-module `uart_byte_tx` serializes one 8N1 frame:
  - inputs: `valid`, `data[7:0]`; output: `ready`;
  - bit counter and baud counter;
  - a one-cycle `frame_done` strobe for gapless chaining.
- The top level of this block holds the edge detect, character map, message sequencer and pending slot. Estimated total is about 200 lines.

## Test plan
- `predicted_digit`=7, single `done` pulse: line decodes 0x37, 0x0D, 0x0A; `busy` high for exactly 26040 cycles; `overrun` never set.
- `predicted_digit`=12: first byte is 0x3F, followed by 0x0D, 0x0A.
- Digit 3, then digit 5 issued 1000 cycles later: two messages, "3\r\n" then "5\r\n", with no idle gap; `busy` high for 52080 cycles continuously.
- Digits 3, 5 and 8 in quick succession (within 1000 cycles): "3\r\n5\r\n" transmitted; one `overrun` pulse for digit 8.
- `rst` asserted during the data bits of byte 1: `uart_tx`=1 and `busy`=0 immediately. A new `done` after release sends a clean full message.
- `done` held high for 100000 cycles with digit 4: exactly one "4\r\n"; `busy` drops after 26040 cycles even though `done` is still high.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and types for the result reporting path: ASCII codes,
// message length, sequencer state encoding and the digit-to-ASCII map.
package mnist_pkg;

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_BAD  = 8'h3F;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam int         MSG_LEN   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } seq_state_e;

    // Digits 0..9 become '0'..'9'; anything else is reported as '?'.
    function automatic logic [7:0] char_of(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return CHAR_ZERO + {4'h0, digit};
        end
        return CHAR_BAD;
    endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result strobe/digit in, serial line and status out.
interface result_uart_tx_if;
    logic       done;
    logic [3:0] predicted_digit;
    logic       uart_tx;
    logic       busy;
    logic       overrun;

    modport slave (
        input  done, predicted_digit,
        output uart_tx, busy, overrun
    );

    modport master (
        output done, predicted_digit,
        input  uart_tx, busy, overrun
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 serializer for one byte. A new byte can be accepted in the last cycle
// of the current stop bit, so consecutive frames leave no idle gap.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       frame_done,
    output logic       tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic          active_q, active_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;      // 0 start, 1..8 data, 9 stop
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign baud_last  = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign frame_done = active_q && baud_last && (bit_q == 4'd9);
    assign ready      = !active_q || frame_done;
    assign tx         = tx_q;

    // Next-state: load a new frame, or advance baud/bit counters.
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        tx_d     = tx_q;
        if (valid && ready) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            data_d   = data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_last) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // State registers; reset idles the line and abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Reports each classifier result as "<digit>\r\n" over an 8N1 UART.
// Holds the done edge detect, character map, message sequencer and a
// one-deep pending slot for a result arriving mid-message.
module result_uart_tx
    import mnist_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic             clk,
    input  logic             rst,
    result_uart_tx_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    seq_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;          // byte of the message now on the line
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_char_q, pend_char_d;
    logic       overrun_q, overrun_d;
    logic       done_q;

    logic       done_edge;
    logic [7:0] cur_char;
    logic       last_byte;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       frame_done;
    logic       tx_line;

    assign done_edge   = bus.done && !done_q;
    assign cur_char    = char_of(bus.predicted_digit);
    assign last_byte   = (idx_q == 2'(MSG_LEN - 1));
    assign bus.uart_tx = tx_line;
    assign bus.busy    = (state_q == ST_SEND);
    assign bus.overrun = overrun_q;

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
        .clk        (clk),
        .rst        (rst),
        .valid      (byte_valid),
        .data       (byte_data),
        .ready      (byte_ready),
        .frame_done (frame_done),
        .tx         (tx_line)
    );

    // Sequencer: start messages, chain bytes on frame_done, manage pending slot.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_vld_d  = pend_vld_q;
        pend_char_d = pend_char_q;
        overrun_d   = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = cur_char;
        unique case (state_q)
            ST_IDLE: begin
                if (done_edge && byte_ready) begin
                    byte_valid = 1'b1;
                    byte_data  = cur_char;
                    idx_d      = 2'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (done_edge) begin
                    if (!pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_char_d = cur_char;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (frame_done) begin
                    if (!last_byte) begin
                        byte_valid = 1'b1;
                        byte_data  = (idx_q == 2'd0) ? CHAR_CR : CHAR_LF;
                        idx_d      = idx_q + 2'd1;
                    end else if (pend_vld_q) begin
                        byte_valid = 1'b1;
                        byte_data  = pend_char_q;
                        idx_d      = 2'd0;
                        pend_vld_d = 1'b0;
                    end else if (done_edge) begin
                        // Edge in the final stop cycle goes straight out,
                        // bypassing the slot it would otherwise occupy.
                        byte_valid = 1'b1;
                        byte_data  = cur_char;
                        idx_d      = 2'd0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer, pending slot, overrun pulse and done edge-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            pend_vld_q  <= 1'b0;
            pend_char_q <= 8'h00;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_vld_q  <= pend_vld_d;
            pend_char_q <= pend_char_d;
            overrun_q   <= overrun_d;
            done_q      <= bus.done;
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at 16 clocks per bit: a line monitor
// decodes frames and busy/overrun activity, and a linear sequence of steps
// checks messages, timing, pending, overrun and reset behaviour.
module tb_result_uart_tx;

    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int CPB    = 16;
    localparam int FRAME  = 10 * CPB;
    localparam int MSG    = 3 * FRAME;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_uart_tx_if bus();

    result_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Monitor state
    int         cyc = 0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_start = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    int         frame_errs = 0;
    int         busy_run = 0;
    int         busy_runs[$];
    int         ovr_pulses = 0;
    int         ovr_cycles = 0;
    logic       ovr_prev = 1'b0;
    logic [7:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst) begin
                rx_act   = 1'b0;
                busy_run = 0;
                ovr_prev = 1'b0;
            end else begin
                if (!rx_act) begin
                    if (bus.uart_tx === 1'b0) begin
                        rx_act   = 1'b1;
                        rx_cnt   = 0;
                        rx_start = cyc;
                    end
                end else begin
                    int k;
                    rx_cnt = rx_cnt + 1;
                    k = rx_cnt - CPB / 2;
                    if (k >= 0 && (k % CPB) == 0) begin
                        if (k / CPB == 0) begin
                            if (bus.uart_tx !== 1'b0) frame_errs++;
                        end else if (k / CPB <= 8) begin
                            rx_sh[k / CPB - 1] = bus.uart_tx;
                        end else begin
                            if (bus.uart_tx !== 1'b1) frame_errs++;
                            rx_bytes.push_back(rx_sh);
                            rx_starts.push_back(rx_start);
                            rx_act = 1'b0;
                        end
                    end
                end
                if (bus.busy === 1'b1) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    busy_runs.push_back(busy_run);
                    busy_run = 0;
                end
                if (bus.overrun === 1'b1) begin
                    ovr_cycles++;
                    if (!ovr_prev) ovr_pulses++;
                end
                ovr_prev = bus.overrun;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int i);
        if (i < rx_bytes.size()) return {24'h0, rx_bytes[i]};
        return 32'hxxxxxxxx;
    endfunction

    task automatic clear_mon();
        rx_bytes.delete();
        rx_starts.delete();
        busy_runs.delete();
        frame_errs = 0;
        ovr_pulses = 0;
        ovr_cycles = 0;
    endtask

    task automatic pulse(input logic [3:0] d);
        bus.predicted_digit = d;
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((bus.busy !== 1'b0 || rx_act) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < limit), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Compare decoded bytes against exp_q and check frames are gapless.
    task automatic check_msg(input string tag);
        check({tag, "_nbytes"}, 32'(rx_bytes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), byte_at(i), {24'h0, exp_q[i]});
        end
        for (int i = 1; i < rx_starts.size(); i++) begin
            check($sformatf("%s_gap%0d", tag, i), 32'(rx_starts[i] - rx_starts[i-1]), 32'(FRAME));
        end
        check({tag, "_framing"}, 32'(frame_errs), 32'd0);
    endtask

    task automatic check_busy(input string tag, input int len);
        check({tag, "_busy_runs"}, 32'(busy_runs.size()), 32'd1);
        if (busy_runs.size() > 0) check({tag, "_busy_len"}, 32'(busy_runs[0]), 32'(len));
    endtask

    initial begin
        bus.done = 1'b0;
        bus.predicted_digit = 4'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ovr", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Digit 7: start-bit latency, message content, busy length.
        clear_mon();
        check("t1_pre_tx", {31'd0, bus.uart_tx}, 32'd1);
        bus.predicted_digit = 4'd7;
        bus.done = 1'b1;
        @(posedge clk);
        #1;
        check("t1_start_tx", {31'd0, bus.uart_tx}, 32'd0);
        check("t1_start_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.done = 1'b0;
        wait_idle("t1", 2000);
        exp_q = {8'h37, 8'h0D, 8'h0A};
        check_msg("t1");
        check_busy("t1", MSG);
        check("t1_ovr", 32'(ovr_cycles), 32'd0);

        // Digit 12 maps to '?'.
        clear_mon();
        pulse(4'd12);
        wait_idle("t2", 2000);
        exp_q = {8'h3F, 8'h0D, 8'h0A};
        check_msg("t2");
        check_busy("t2", MSG);

        // Second result mid-message goes to the pending slot, sent gapless.
        clear_mon();
        pulse(4'd3);
        repeat (50) @(negedge clk);
        pulse(4'd5);
        wait_idle("t3", 3000);
        exp_q = {8'h33, 8'h0D, 8'h0A, 8'h35, 8'h0D, 8'h0A};
        check_msg("t3");
        check_busy("t3", 2 * MSG);
        check("t3_ovr", 32'(ovr_cycles), 32'd0);

        // Third result with the slot full is dropped with one overrun pulse.
        clear_mon();
        pulse(4'd3);
        repeat (20) @(negedge clk);
        pulse(4'd5);
        repeat (20) @(negedge clk);
        pulse(4'd8);
        wait_idle("t4", 3000);
        exp_q = {8'h33, 8'h0D, 8'h0A, 8'h35, 8'h0D, 8'h0A};
        check_msg("t4");
        check_busy("t4", 2 * MSG);
        check("t4_ovr_pulses", 32'(ovr_pulses), 32'd1);
        check("t4_ovr_width", 32'(ovr_cycles), 32'd1);

        // Reset during byte 1 data bits, then a clean message afterwards.
        clear_mon();
        pulse(4'd7);
        repeat (220) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_rst_ovr", {31'd0, bus.overrun}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        pulse(4'd9);
        wait_idle("t5", 2000);
        exp_q = {8'h39, 8'h0D, 8'h0A};
        check_msg("t5");
        check_busy("t5", MSG);

        // done held high: exactly one message, busy drops while done stays high.
        clear_mon();
        bus.predicted_digit = 4'd4;
        bus.done = 1'b1;
        repeat (1200) @(negedge clk);
        check("t6_busy_low_while_held", {31'd0, bus.busy}, 32'd0);
        bus.done = 1'b0;
        wait_idle("t6", 2000);
        exp_q = {8'h34, 8'h0D, 8'h0A};
        check_msg("t6");
        check_busy("t6", MSG);

        // Edge in the last cycle of the final stop bit chains back to back.
        clear_mon();
        pulse(4'd1);
        bus.predicted_digit = 4'd2;
        repeat (MSG - 1) @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        wait_idle("t7", 3000);
        exp_q = {8'h31, 8'h0D, 8'h0A, 8'h32, 8'h0D, 8'h0A};
        check_msg("t7");
        check_busy("t7", 2 * MSG);
        check("t7_ovr", 32'(ovr_cycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
